mem_word_ctrl: RTL and testbench

- Sequencer between the multi-cycle datapath and the 16-bit-wide main memory.
- Accepts one 32-bit load or store request at a time over a valid/ready handshake.
- Splits each request into two 16-bit memory accesses: low half at addr, high half at addr+1.
- Assembles the 32-bit load result in a held data register and returns it with a one-cycle resp_valid pulse.

---
 rtl/mem_word_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_word_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: sequencer between the datapath and a MEM_W-wide main memory.
// Each 32-bit request becomes two memory accesses: the low half at addr, then
// the high half at addr+1 (wrapping at the top of memory). Loads are assembled
// into resp_rdata, which holds its value until the next load completes. Every
// request, load or store, ends with a one-cycle resp_valid pulse.
//
// Optional build macro MEM_WORD_CTRL_ALIGN_CHECK_EN adds an err output. With
// it, a request at an odd address makes no memory access and finishes
// immediately with err=1. Without it, odd addresses are processed normally.

module mem_word_ctrl #(
    parameter int ADDR_W = 13,
    parameter int MEM_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [2*MEM_W-1:0]   req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [2*MEM_W-1:0]   resp_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [MEM_W-1:0]     mem_write_data,
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
    output logic                 err,
`endif
    input  logic [MEM_W-1:0]     mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Sequencer state and the request fields captured at accept.
    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*MEM_W-1:0]    wdata_q;
    logic                  write_q;

    // Registered outputs. They are loaded with the value the next state needs,
    // so every port comes straight from a flop.
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [2*MEM_W-1:0]    resp_rdata_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_W-1:0]     mem_address_q;
    logic [MEM_W-1:0]      mem_write_data_q;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
    logic                  err_q;
`endif

    // Address of the high half. It is truncated to ADDR_W, so the top
    // address wraps to 0.
    logic [ADDR_W-1:0]     addr_hi_d;
    assign addr_hi_d = addr_q + ADDR_W'(1);

    // Misaligned requests take the short IDLE->DONE path only in the
    // alignment-checking build.
    logic                  misaligned_d;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
    assign misaligned_d = req_addr[0];
`else
    assign misaligned_d = 1'b0;
`endif

    // Sequencer: advance the state, capture the request, and register all outputs.
    // NOTE: state is updated with non-blocking assignments so that every
    // right-hand side reads the value from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            wdata_q          <= '0;
            write_q          <= 1'b0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
            err_q            <= 1'b0;
`endif
        end else begin
            // These pulse outputs fall back to 0 unless a branch below sets them.
            resp_valid_q <= 1'b0;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        req_ready_q <= 1'b0;
                        if (misaligned_d) begin
                            // Finish immediately. The memory stays idle and
                            // resp_rdata keeps its value.
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
                            err_q        <= 1'b1;
`endif
                        end else begin
                            // Set up the low-half access for the LO cycle.
                            state_q          <= S_LO;
                            mem_read_q       <= ~req_write;
                            mem_write_q      <= req_write;
                            mem_address_q    <= req_addr;
                            mem_write_data_q <= req_write ? req_wdata[MEM_W-1:0] : '0;
                        end
                    end
                end

                S_LO: begin
                    // Keep the low half of a load. Switch the memory side
                    // to the high-half access.
                    if (!write_q) begin
                        resp_rdata_q[MEM_W-1:0] <= mem_read_data;
                    end
                    state_q          <= S_HI;
                    mem_address_q    <= addr_hi_d;
                    mem_write_data_q <= write_q ? wdata_q[2*MEM_W-1:MEM_W] : '0;
                end

                S_HI: begin
                    // Keep the high half of a load. Release the memory and
                    // raise the completion pulse for DONE.
                    if (!write_q) begin
                        resp_rdata_q[2*MEM_W-1:MEM_W] <= mem_read_data;
                    end
                    state_q          <= S_DONE;
                    mem_read_q       <= 1'b0;
                    mem_write_q      <= 1'b0;
                    mem_address_q    <= '0;
                    mem_write_data_q <= '0;
                    resp_valid_q     <= 1'b1;
                end

                S_DONE: begin
                    // The completion pulse is dropped by the default above.
                    // Reopen for the next request.
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
    assign err            = err_q;
`endif

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Testbench for mem_word_ctrl. A 16-bit memory array is attached to the DUT's
// memory port. A transaction-level reference keeps the expected memory image
// and the expected load results, and the bench checks the DUT cycle by cycle
// against them, using directed cases and then randomized ones.

module tb_mem_word_ctrl;

    localparam int AW    = 13;
    localparam int MW    = 16;
    localparam int DEPTH = 1 << AW;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [2*MW-1:0] req_wdata;
    logic            req_ready;
    logic            resp_valid;
    logic [2*MW-1:0] resp_rdata;
    logic            mem_read;
    logic            mem_write;
    logic [AW-1:0]   mem_address;
    logic [MW-1:0]   mem_write_data;
    logic [MW-1:0]   mem_read_data;
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
    logic            err;
`endif

    mem_word_ctrl #(.ADDR_W(AW), .MEM_W(MW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
        .err            (err),
`endif
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The memory the DUT drives. Reads are combinational and writes happen
    // on the clock edge.
    logic [MW-1:0] mem     [DEPTH];
    logic [MW-1:0] ref_mem [DEPTH];
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
    end

    int            n_checks;
    int            n_errors;
    logic [31:0]   last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // A read and a write must never be issued in the same cycle.
    always @(negedge clk) begin
        if (rst) check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
    end

    // Drive junk on the request port while the DUT is busy. The DUT must
    // ignore it.
    task automatic busy_drive(input bit hold);
        req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
    endtask

    // Run one request from accept to completion and check every cycle.
    // If abort_hi is set, reset is pulled low in the HI cycle.
    task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                          input bit hold, input bit abort_hi);
        int          n;
        int          ahi;
        logic [31:0] exp;
        ahi = (int'(a) + 1) % DEPTH;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(req_ready), 32'd1);
        check("idle_no_read", 32'(mem_read), 32'd0);
        check("idle_no_write", 32'(mem_write), 32'd0);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
        if (a[0]) begin
            check("odd_resp_valid", 32'(resp_valid), 32'd1);
            check("odd_err", 32'(err), 32'd1);
            check("odd_no_read", 32'(mem_read), 32'd0);
            check("odd_no_write", 32'(mem_write), 32'd0);
            check("odd_rdata_held", resp_rdata, last_rdata);
            check("odd_not_ready", 32'(req_ready), 32'd0);
            busy_drive(hold);
            return;
        end
        check("lo_err", 32'(err), 32'd0);
`endif
        // LO cycle: access the low half.
        check("lo_not_ready", 32'(req_ready), 32'd0);
        check("lo_read", 32'(mem_read), 32'(!w));
        check("lo_write", 32'(mem_write), 32'(w));
        check("lo_addr", 32'(mem_address), 32'(a));
        if (w) check("lo_wdata", 32'(mem_write_data), 32'(d[15:0]));
        check("lo_no_resp", 32'(resp_valid), 32'd0);
        busy_drive(hold);
        @(negedge clk);
        // HI cycle: access the high half.
        check("hi_not_ready", 32'(req_ready), 32'd0);
        check("hi_read", 32'(mem_read), 32'(!w));
        check("hi_write", 32'(mem_write), 32'(w));
        check("hi_addr", 32'(mem_address), 32'(ahi));
        if (w) check("hi_wdata", 32'(mem_write_data), 32'(d[31:16]));
        check("hi_no_resp", 32'(resp_valid), 32'd0);
        if (abort_hi) begin
            rst = 1'b0;
            #1;
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_resp", 32'(resp_valid), 32'd0);
            check("rst_rdata", resp_rdata, 32'd0);
            check("rst_read", 32'(mem_read), 32'd0);
            check("rst_write", 32'(mem_write), 32'd0);
            check("rst_addr", 32'(mem_address), 32'd0);
            check("rst_wdata", 32'(mem_write_data), 32'd0);
            if (w) ref_mem[a] = d[15:0];
            last_rdata = '0;
            req_valid = 1'b0;
            @(negedge clk);
            check("abort_lo_written", 32'(mem[a]), 32'(ref_mem[a]));
            check("abort_hi_untouched", 32'(mem[ahi]), 32'(ref_mem[ahi]));
            rst = 1'b1;
            return;
        end
        busy_drive(hold);
        @(negedge clk);
        // DONE cycle: the completion pulse.
        if (!w) last_rdata = {ref_mem[ahi], ref_mem[a]};
        else begin
            ref_mem[a]   = d[15:0];
            ref_mem[ahi] = d[31:16];
        end
        check("done_resp_valid", 32'(resp_valid), 32'd1);
        check("done_rdata", resp_rdata, last_rdata);
        check("done_no_read", 32'(mem_read), 32'd0);
        check("done_no_write", 32'(mem_write), 32'd0);
        check("done_addr_zero", 32'(mem_address), 32'd0);
        check("done_not_ready", 32'(req_ready), 32'd0);
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
        check("done_err", 32'(err), 32'd0);
`endif
        if (w) begin
            check("store_lo_mem", 32'(mem[a]), 32'(ref_mem[a]));
            check("store_hi_mem", 32'(mem[ahi]), 32'(ref_mem[ahi]));
        end
        busy_drive(hold);
    endtask

    // The run is bounded. A hang is reported and the bench stops.
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [MW-1:0] v;
        int            nmis;
        n_checks   = 0;
        n_errors   = 0;
        last_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v          = MW'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_resp", 32'(resp_valid), 32'd0);
        check("reset_rdata", resp_rdata, 32'd0);
        check("reset_read", 32'(mem_read), 32'd0);
        check("reset_write", 32'(mem_write), 32'd0);
        check("reset_addr", 32'(mem_address), 32'd0);
        check("reset_wdata", 32'(mem_write_data), 32'd0);
`ifdef MEM_WORD_CTRL_ALIGN_CHECK_EN
        check("reset_err", 32'(err), 32'd0);
`endif
        rst = 1'b1;

        // Directed cases.
        do_txn(1'b1, AW'(1000), 32'hDEADBEEF, 1'b0, 1'b0);
        do_txn(1'b0, AW'(1000), 32'h0, 1'b0, 1'b0);
        do_txn(1'b0, AW'(8191), 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_txn(1'(i % 2 == 0), AW'(20), $urandom, 1'b1, 1'b0);
        end
        do_txn(1'b1, AW'(40), 32'h12345678, 1'b0, 1'b1);
        do_txn(1'b0, AW'(40), 32'h0, 1'b0, 1'b0);
        do_txn(1'b0, AW'(7), 32'h0, 1'b0, 1'b0);
        do_txn(1'b1, AW'(8191), 32'hCAFEF00D, 1'b0, 1'b0);
        do_txn(1'b0, AW'(8191), 32'h0, 1'b0, 1'b0);

        // Randomized traffic, with a bias toward the wrap boundary and a
        // few low addresses.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = AW'(DEPTH - 1);
                1:       ra = AW'($urandom_range(0, 7));
                default: ra = AW'($urandom);
            endcase
            do_txn(1'($urandom_range(0, 1)), ra, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        nmis = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) nmis++;
        end
        check("final_mem_image_mismatches", 32'(nmis), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
